// File: rtl/mcbsp_pkg.sv
// rtl/mcbsp_pkg.sv - shared types and constants for the DSP-end McBSP transmitter
// Purpose: FSM state encoding, default frame word length and word-count width.
// Ports: none (package).
package mcbsp_pkg;

  localparam int CODE_LENGTH_DEF = 32;
  localparam int WCNT_W          = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IRQ,
    ST_WAIT,
    ST_FETCH,
    ST_SYNC,
    ST_SHIFT,
    ST_GAP,
    ST_DONE
  } tx_state_t;

endpackage

// File: rtl/mcbsp_bitclk_gen.sv
// rtl/mcbsp_bitclk_gen.sv - McBSP bit clock divider with rise/fall strobes
// Purpose: produce clkx = clk/(2*HALF_DIV) while enabled; parked low when disabled.
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   en          run the divider; low forces clkx low and restarts the phase
//   clkx        divided bit clock
//   rise, fall  one-clock strobes in the cycle before clkx goes high / low
module mcbsp_bitclk_gen #(
  parameter int HALF_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic clkx,
  output logic rise,
  output logic fall
);

  localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          tick;

  assign tick = en && (cnt == CW'(HALF_DIV - 1));
  assign rise = tick && !clkx;
  assign fall = tick && clkx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      clkx <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      clkx <= 1'b0;
    end else if (tick) begin
      cnt  <= '0;
      clkx <= ~clkx;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mcbsp_dsp_tx_emu.sv
// rtl/mcbsp_dsp_tx_emu.sv - DSP-end McBSP burst transmitter (clkx/fsx/mosi + tx interrupt)
// Purpose: fetch a burst of words over a req/valid handshake and send each one
//   MSB-first as a McBSP frame (one fsx bit, data delay 1).
// Build option: MCBSP_TX_CHECKSUM_EN appends one frame carrying the 32-bit sum
//   (mod 2^32) of the burst words.
// Ports:
//   mcbsp_clk_in, mcbsp_rst_n_in  system clock, asynchronous active-low reset
//   tx_start, tx_word_count       start pulse and burst length (sampled on start)
//   tx_data_req/in/valid          word source handshake
//   mcbsp_tx_interrupt            arms the receiver before the first frame
//   mcbsp_slaver_clkx/fsx/mosi    serial link
//   tx_busy, tx_done, tx_underrun burst status
module mcbsp_dsp_tx_emu
  import mcbsp_pkg::*;
#(
  parameter int CODE_LENGTH   = CODE_LENGTH_DEF,
  parameter int HALF_DIV      = 1,
  parameter int IRQ_CYCLES    = 4,
  parameter int IRQ_TO_FS_DLY = 16,
  parameter int FRAME_GAP     = 0
) (
  input  logic              mcbsp_clk_in,
  input  logic              mcbsp_rst_n_in,
  input  logic              tx_start,
  input  logic [WCNT_W-1:0] tx_word_count,
  output logic              tx_data_req,
  input  logic [31:0]       tx_data_in,
  input  logic              tx_data_valid,
  output logic              mcbsp_tx_interrupt,
  output logic              mcbsp_slaver_clkx,
  output logic              mcbsp_slaver_fsx,
  output logic              mcbsp_slaver_mosi,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              tx_underrun
);

  localparam int BCW = $clog2(CODE_LENGTH + 1);

  tx_state_t              state;
  logic [15:0]            cnt;        // clocks in IRQ/WAIT, bit periods in GAP
  logic [BCW-1:0]         bit_cnt;    // index of the bit currently on mosi
  logic [CODE_LENGTH-1:0] shreg;
  logic [CODE_LENGTH-1:0] shadow;
  logic                   shadow_valid;
  logic [WCNT_W-1:0]      remain;     // words not yet accepted from the source

  logic                   bit_en;
  logic                   bit_rise;
  logic                   bit_fall;
  logic                   handshake;
  logic                   last_bit;
  logic                   next_ok;
  logic [CODE_LENGTH-1:0] next_word;

`ifdef MCBSP_TX_CHECKSUM_EN
  logic [31:0]            sum;
  logic                   sum_pending;
  logic                   next_is_sum;
`endif

  assign bit_en    = (state == ST_SYNC) || (state == ST_SHIFT) || (state == ST_GAP);
  assign handshake = tx_data_req && tx_data_valid;
  assign last_bit  = (bit_cnt == BCW'(CODE_LENGTH - 1));

  mcbsp_bitclk_gen #(
    .HALF_DIV (HALF_DIV)
  ) u_bitclk (
    .clk   (mcbsp_clk_in),
    .rst_n (mcbsp_rst_n_in),
    .en    (bit_en),
    .clkx  (mcbsp_slaver_clkx),
    .rise  (bit_rise),
    .fall  (bit_fall)
  );

  // Word for the following frame. A handshake landing on the very last bit
  // still counts, so a late source is not mistaken for an underrun.
  always_comb begin
    next_ok   = 1'b0;
    next_word = shadow;
`ifdef MCBSP_TX_CHECKSUM_EN
    next_is_sum = 1'b0;
`endif
    if (shadow_valid) begin
      next_ok = 1'b1;
    end else if (handshake) begin
      next_ok   = 1'b1;
      next_word = tx_data_in[CODE_LENGTH-1:0];
    end
`ifdef MCBSP_TX_CHECKSUM_EN
    else if (remain == '0 && sum_pending) begin
      next_ok     = 1'b1;
      next_word   = sum[CODE_LENGTH-1:0];
      next_is_sum = 1'b1;
    end
`endif
  end

  always_ff @(posedge mcbsp_clk_in or negedge mcbsp_rst_n_in) begin
    if (!mcbsp_rst_n_in) begin
      state              <= ST_IDLE;
      cnt                <= '0;
      bit_cnt            <= '0;
      shreg              <= '0;
      shadow             <= '0;
      shadow_valid       <= 1'b0;
      remain             <= '0;
      tx_data_req        <= 1'b0;
      mcbsp_tx_interrupt <= 1'b0;
      mcbsp_slaver_fsx   <= 1'b0;
      mcbsp_slaver_mosi  <= 1'b0;
      tx_busy            <= 1'b0;
      tx_done            <= 1'b0;
      tx_underrun        <= 1'b0;
`ifdef MCBSP_TX_CHECKSUM_EN
      sum                <= '0;
      sum_pending        <= 1'b0;
`endif
    end else begin
      tx_done     <= 1'b0;
      tx_underrun <= 1'b0;
`ifdef MCBSP_TX_CHECKSUM_EN
      if (handshake) sum <= sum + tx_data_in;
`endif
      case (state)
        ST_IDLE: begin
          if (tx_start && tx_word_count != '0) begin
            remain             <= tx_word_count;
            tx_busy            <= 1'b1;
            mcbsp_tx_interrupt <= 1'b1;
            cnt                <= '0;
            state              <= ST_IRQ;
`ifdef MCBSP_TX_CHECKSUM_EN
            sum                <= '0;
            sum_pending        <= 1'b1;
`endif
          end
        end
        ST_IRQ: begin
          if (cnt == 16'(IRQ_CYCLES - 1)) begin
            mcbsp_tx_interrupt <= 1'b0;
            cnt                <= '0;
            state              <= ST_WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt == 16'(IRQ_TO_FS_DLY - 1)) begin
            cnt         <= '0;
            tx_data_req <= 1'b1;
            state       <= ST_FETCH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_FETCH: begin
          // clkx is parked low here, so raising fsx now still meets the
          // "change while clkx is low" rule for the receiver.
          if (handshake) begin
            tx_data_req       <= 1'b0;
            shreg             <= tx_data_in[CODE_LENGTH-1:0];
            remain            <= remain - 1'b1;
            mcbsp_slaver_fsx  <= 1'b1;
            mcbsp_slaver_mosi <= 1'b0;
            state             <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (bit_fall) begin
            mcbsp_slaver_fsx  <= 1'b0;
            mcbsp_slaver_mosi <= shreg[CODE_LENGTH-1];
            shreg             <= {shreg[CODE_LENGTH-2:0], 1'b0};
            bit_cnt           <= '0;
            state             <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bit_rise && bit_cnt == '0 && remain != '0 && !shadow_valid)
            tx_data_req <= 1'b1;
          if (handshake) begin
            shadow       <= tx_data_in[CODE_LENGTH-1:0];
            shadow_valid <= 1'b1;
            tx_data_req  <= 1'b0;
            remain       <= remain - 1'b1;
          end
          // Frame-end decisions come last so they override the handshake above.
          if (bit_fall) begin
            if (!last_bit) begin
              mcbsp_slaver_mosi <= shreg[CODE_LENGTH-1];
              shreg             <= {shreg[CODE_LENGTH-2:0], 1'b0};
              bit_cnt           <= bit_cnt + 1'b1;
            end else if (next_ok) begin
              shreg             <= next_word;
              shadow_valid      <= 1'b0;
              mcbsp_slaver_mosi <= 1'b0;
`ifdef MCBSP_TX_CHECKSUM_EN
              if (next_is_sum) sum_pending <= 1'b0;
`endif
              if (FRAME_GAP == 0) begin
                mcbsp_slaver_fsx <= 1'b1;
                state            <= ST_SYNC;
              end else begin
                cnt   <= '0;
                state <= ST_GAP;
              end
            end else begin
              mcbsp_slaver_mosi <= 1'b0;
              tx_data_req       <= 1'b0;
              tx_underrun       <= (remain != '0);
              state             <= ST_DONE;
            end
          end
        end
        ST_GAP: begin
          if (bit_fall) begin
            if (cnt == 16'(FRAME_GAP - 1)) begin
              cnt              <= '0;
              mcbsp_slaver_fsx <= 1'b1;
              state            <= ST_SYNC;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_DONE: begin
          tx_done <= 1'b1;
          tx_busy <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
